// File: rtl/arb_pkg.sv
// ============================================================================
// Module : arb_pkg
// Brief  : Shared sizes and state encoding for the 8-way round-robin arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package arb_pkg;
    localparam int N_REQ  = 8;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;
endpackage

`default_nettype wire

// File: rtl/rr_pick8.sv
// ============================================================================
// Module : rr_pick8
// Brief  : Combinational circular priority picker, scan starts at ptr.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] w_cand;

    // Scanning from the far end down lets the candidate nearest ptr win last.
    always_comb begin
        found  = 1'b0;
        idx    = ptr;
        w_cand = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = ptr + SEL_W'(k);
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux8_rr_arbiter.sv
// ============================================================================
// Module : mux8_rr_arbiter
// Brief  : 8-requester round-robin arbiter with burst limit and 8:1 data mux.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mux8_rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_BEATS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] din,
    input  logic                    out_ready,
    output logic [N_REQ-1:0]        grant,
    output logic [SEL_W-1:0]        sel,
    output logic [DATA_W-1:0]       o,
    output logic                    out_valid,
    output logic                    busy
);

    localparam logic [3:0] c_LAST_BEAT = 4'(MAX_BEATS - 1);

    arb_state_t       r_state;
    logic [N_REQ-1:0] r_grant;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_ptr;
    logic [3:0]       r_beat_cnt;

    logic             w_found;
    logic [SEL_W-1:0] w_idx;
    logic             w_owner_req;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    assign w_owner_req = req[r_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_sel      <= '0;
            r_ptr      <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state    <= BUSY;
                        r_grant    <= N_REQ'(1) << w_idx;
                        r_sel      <= w_idx;
                        r_beat_cnt <= '0;
                    end
                end
                BUSY: begin
                    // Withdrawal and burst completion both hand priority to the next index.
                    if (!w_owner_req) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_ptr   <= r_sel + SEL_W'(1);
                    end else if (out_ready) begin
                        if (r_beat_cnt == c_LAST_BEAT) begin
                            r_state <= IDLE;
                            r_grant <= '0;
                            r_ptr   <= r_sel + SEL_W'(1);
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign sel       = r_sel;
    assign o         = din[{r_sel, 3'b000} +: DATA_W];
    assign busy      = (r_state == BUSY) && !rst;
    assign out_valid = busy && w_owner_req;

endmodule

`default_nettype wire

// File: tb/tb_mux8_rr_arbiter.sv
// ============================================================================
// Module : tb_mux8_rr_arbiter
// Brief  : Self-checking bench: per-cycle reference model plus directed pins.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mux8_rr_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  req;
    logic [63:0] din;
    logic        out_ready;
    logic [7:0]  grant;
    logic [2:0]  sel;
    logic [7:0]  o;
    logic        out_valid;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the output, where the scan starts, beats done.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_beats = 0;

    mux8_rr_arbiter #(.MAX_BEATS(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .out_ready (out_ready),
        .grant     (grant),
        .sel       (sel),
        .o         (o),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick_winner(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_compare();
        logic [7:0] e_grant;
        e_grant = m_busy ? (8'd1 << m_owner) : 8'd0;
        chk("m_grant", grant, e_grant);
        chk("m_sel", sel, m_owner);
        chk("m_busy", busy, m_busy && !rst);
        chk("m_out_valid", out_valid, m_busy && !rst && req[m_owner]);
        chk("m_o", o, din[m_owner*8 +: 8]);
    endtask

    task automatic model_advance();
        int w;
        if (rst) begin
            m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_beats = 0;
        end else if (!m_busy) begin
            w = pick_winner(req, m_ptr);
            if (w >= 0) begin
                m_busy = 1'b1; m_owner = w; m_beats = 0;
            end
        end else if (!req[m_owner]) begin
            m_busy = 1'b0; m_ptr = (m_owner + 1) % 8;
        end else if (out_ready) begin
            m_beats++;
            if (m_beats == MB) begin
                m_busy = 1'b0; m_ptr = (m_owner + 1) % 8;
            end
        end
    endtask

    // One clock: drive at negedge, compare model, take the edge, advance model.
    task automatic step(input logic r, input logic [7:0] q, input logic [63:0] d, input logic rdy);
        @(negedge clk);
        rst = r; req = q; din = d; out_ready = rdy;
        #1;
        model_compare();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    logic [7:0] exp028 [10];
    logic [7:0] exp029 [20];
    logic [63:0] d030;
    logic [7:0] prev_g;
    int n_new;

    initial begin
        rst = 1'b1; req = '0; din = '0; out_ready = 1'b0;
        exp028 = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
        exp029 = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00,
                   8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};

        // Reset state
        step(1, 8'h00, 64'h0, 0);
        step(1, 8'h00, 64'h0, 0);
        chk("rst_grant", grant, 8'h00);
        chk("rst_sel", sel, 3'd0);
        chk("rst_busy", busy, 1'b0);

        // Single requester, 4-beat bursts separated by one idle cycle
        for (int i = 0; i < 10; i++) begin
            step(0, 8'h01, 64'h0123_4567_89AB_CDEF, 1);
            chk("single_grant", grant, exp028[i]);
        end

        // Two requesters alternate 0,7,0,7
        step(1, 8'h00, 64'h0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 8'h81, 64'hFF00_0000_0000_00EE, 1);
            chk("alt_grant", grant, exp029[i]);
        end

        // Back-pressure on requester 3
        step(1, 8'h00, 64'h0, 0);
        d030 = 64'h1111_1111_A511_1111;
        step(0, 8'h08, d030, 0);
        chk("bp_grant", grant, 8'h08);
        for (int i = 0; i < 5; i++) begin
            step(0, 8'h08, d030, 0);
            chk("bp_o", o, 8'hA5);
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_hold", grant, 8'h08);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h08, d030, 1);
            chk("bp_drain", grant, (i == 3) ? 8'h00 : 8'h08);
        end

        // Withdrawal by requester 5 moves the scan start to 6
        step(1, 8'h00, 64'h0, 0);
        step(0, 8'h20, 64'h0, 1);
        chk("wd_grant5", grant, 8'h20);
        step(0, 8'h20, 64'h0, 1);
        step(0, 8'h20, 64'h0, 1);
        step(0, 8'h01, 64'h0, 1);
        chk("wd_idle", grant, 8'h00);
        step(0, 8'h21, 64'h0, 1);
        chk("wd_next", grant, 8'h01);

        // Reset mid-burst
        step(1, 8'h00, 64'h0, 0);
        step(0, 8'hFF, 64'h0, 1);
        step(0, 8'hFF, 64'h0, 1);
        step(0, 8'hFF, 64'h0, 1);
        step(1, 8'hFF, 64'h0, 1);
        chk("mid_rst_grant", grant, 8'h00);
        chk("mid_rst_sel", sel, 3'd0);
        chk("mid_rst_busy", busy, 1'b0);
        step(0, 8'hFF, 64'h0, 1);
        chk("mid_rst_regrant", grant, 8'h01);

        // All requesters: new grants rotate 1,2,..,7,0,1 after the first
        prev_g = grant;
        n_new = 1;
        for (int i = 0; i < 60; i++) begin
            step(0, 8'hFF, 64'h0, 1);
            if (grant != 8'h00 && prev_g == 8'h00) begin
                chk("rotate", grant, 8'd1 << (n_new % 8));
                n_new++;
            end
            prev_g = grant;
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 79) == 0,
                 ($urandom_range(0, 4) == 0) ? 8'h00 : (8'($urandom) | 8'($urandom)),
                 {$urandom, $urandom},
                 $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux8_rr_arbiter.md
MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

Interface
REQ-001 Parameter MAX_BEATS, default 4, meaning max transfers per grant before forced re-arbitration; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  8  per-requester request; bit i = requester i.
REQ-005 din  input  64  requester data, packed; requester i at din[8i+7:8i].
REQ-006 out_ready  input  1  downstream accepts beat this cycle.
REQ-007 grant  output  8  one-hot registered grant, all-zero when idle.
REQ-008 sel  output  3  index of granted requester; drives the 8:1 select.
REQ-009 o  output  8  selected data = din slice at sel, combinational from sel.
REQ-010 out_valid  output  1  beat offered downstream.
REQ-011 busy  output  1  high in state BUSY.

Function
REQ-012 Two states: IDLE, BUSY. State, grant, sel, ptr and beat_cnt are registered; o and out_valid are combinational.
REQ-013 IDLE with req==0: stay IDLE; grant=0, out_valid=0.
REQ-014 IDLE with req!=0: pick the first set bit scanning circularly from ptr upward (ptr, ptr+1 .. 7, 0 .. ptr-1). Next cycle: BUSY, grant one-hot at winner, sel=winner, beat_cnt=0. Grant latency is exactly 1 cycle.
REQ-015 BUSY: out_valid = req[sel]; beat = out_valid & out_ready.
REQ-016 BUSY with beat and beat_cnt==MAX_BEATS-1: next cycle IDLE, grant=0, ptr=(sel+1) mod 8.
REQ-017 BUSY with req[sel]==0 (requester withdrew): next cycle IDLE, ptr=(sel+1) mod 8; no beat counted that cycle.
REQ-018 BUSY with beat otherwise: beat_cnt increments; grant and sel unchanged.
REQ-019 BUSY with out_valid and !out_ready: hold all state; o stable (back-pressure).
REQ-020 Requests from non-granted requesters are ignored while BUSY; requests are not latched.
REQ-021 sel retains its last value in IDLE (o keeps showing last granted source); grant is zero in IDLE.
REQ-022 ptr wraps 7 -> 0. Every requester holding req continuously is granted within 8 arbitration rounds (no starvation).
REQ-023 Arbitration is always one idle cycle after release: back-to-back grants are separated by exactly one IDLE cycle.

Reset
REQ-024 When rst is high at a clock edge: state=IDLE, grant=0, sel=0, ptr=0, beat_cnt=0. This applies in any state, including mid-transfer. The in-flight grant is dropped with no completion beat.
REQ-025 While rst is high, out_valid=0 and busy=0. Reset has priority over every transition.

Structure
REQ-026 Shared package arb_pkg: N_REQ=8, DATA_W=8, SEL_W=3, state typedef {IDLE, BUSY}.
REQ-027 One sub-module: rr_pick8 (combinational; inputs req[7:0] and ptr[2:0]; outputs found and idx[2:0]). The data mux is an inline 8:1, 8-bit select on sel.

Verification
REQ-028 Reset, then req=8'h01 and out_ready=1 held -> grant=8'h01 one cycle later; 4 beats; IDLE for 1 cycle; regrant to requester 0 (only requester).
REQ-029 ptr=0, req=8'h81 held, out_ready=1 -> grants alternate 0,7,0,7; each grant gives 4 beats.
REQ-030 Granted requester 3, din[31:24]=8'hA5, out_ready=0 for 5 cycles -> o=8'hA5 and out_valid=1 stable, beat_cnt unchanged; then out_ready=1 -> 4 beats complete.
REQ-031 Granted requester 5; req[5] drops after 2 beats -> IDLE next cycle, ptr=6; with req=8'h21 the next grant is requester 0 (scan order 6,7,0).
REQ-032 rst pulsed mid-BUSY at beat 2 -> next cycle grant=0, sel=0, busy=0; with req=8'hFF the next grant is requester 0.
REQ-033 All 8 requesters held, MAX_BEATS=1 -> grants cycle 0..7 in order, then wrap back to 0.
